// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore control sequencer for a 16-bit single-bus datapath
//
// Fetches an instruction over the shared bus into IR, decodes it and steps the
// datapath strobes one state per clock. Memory accesses wait on MFC. If MFC does
// not arrive within MFC_TIMEOUT cycles, the unit latches memFault and halts.
//
// Parameters
//   MFC_TIMEOUT  cycles spent in a memory wait before a fault (1..255)
// Configuration macro
//   CU_IO_INSTR_EN  when defined, enables opcode 0x5 (IN) and 0x6 (OUT).
//                   When undefined, both opcodes run as NOP and p0Latch and p1Out stay 0.
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   busIn[15:0]               bus value captured into IR during the fetch
//   MFC                       memory function complete
//   ALUin0/ALUin1             ALU operand register latches
//   ALUOutLatch/ALUOutEn      ALU result latch and bus drive
//   opControl[2:0]            ALU operation (IR[7:5] while ALUOutLatch, else 0)
//   PCOutEn/PCInc             PC bus drive, PC increment pulse
//   rLatch[3:0]/rOut[3:0]     register file latch / bus drive, bit n = rn
//   memEN/memRW               memory cycle request, 1 = read, 0 = write
//   MARin                     MAR latch
//   MDRwriteEN/MDRreadEN      MDR load from bus / load from memory
//   MDRout                    MDR bus drive
//   p0Latch/p1Out             output port latch, input port bus drive
//   halted/memFault           sticky status flags

module control_unit #(
    parameter int MFC_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] busIn,
    input  logic        MFC,
    output logic        ALUin0,
    output logic        ALUin1,
    output logic        ALUOutLatch,
    output logic        ALUOutEn,
    output logic [2:0]  opControl,
    output logic        PCOutEn,
    output logic        PCInc,
    output logic [3:0]  rLatch,
    output logic [3:0]  rOut,
    output logic        memEN,
    output logic        memRW,
    output logic        MARin,
    output logic        MDRwriteEN,
    output logic        MDRreadEN,
    output logic        MDRout,
    output logic        p0Latch,
    output logic        p1Out,
    output logic        halted,
    output logic        memFault
);

    typedef enum logic [4:0] {
        F_ADDR, F_MEM, F_RD, F_IR, DECODE,
        A0, A1, AL, AW,
        L_A, L_M, L_D, L_W,
        S_A, S_D, S_M,
        MV,
        I_R, O_W,
        HALT
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(MFC_TIMEOUT - 1);

    state_t      state, next_state;
    logic [15:0] ir;
    logic [7:0]  wcnt;
    logic        run;
    logic        mem_fault_q;
    logic        load_ir;
    logic        set_fault;
    logic        in_wait;
    logic        timed_out;
    logic [3:0]  rd_oh, rs_oh;
    logic        unused_ir_bits;

    // IR[4:0] carries no control information
    assign unused_ir_bits = ^ir[4:0];

    assign rd_oh     = 4'b0001 << ir[11:10];
    assign rs_oh     = 4'b0001 << ir[9:8];
    assign in_wait   = (state == F_MEM) || (state == L_M) || (state == S_M);
    // wcnt counts completed wait cycles, so the current cycle is the last
    // allowed one when wcnt reaches MFC_TIMEOUT-1
    assign timed_out = (wcnt == LAST_WAIT);
    assign memFault  = mem_fault_q;

    // run stays low for the partial cycle after reset release, so every strobe
    // stays low until the first full clock period. It also keeps F_ADDR from
    // being shortened by a reset release close to a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= F_ADDR;
            ir          <= 16'h0000;
            wcnt        <= 8'd0;
            run         <= 1'b0;
            mem_fault_q <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= next_state;
            if (load_ir) begin
                ir <= busIn;
            end
            if (set_fault) begin
                mem_fault_q <= 1'b1;
            end
            // Wait states never follow each other directly, so staying in the
            // same wait state is the only case that keeps counting.
            // Every entry starts from zero.
            if (in_wait && (next_state == state)) begin
                wcnt <= wcnt + 8'd1;
            end else begin
                wcnt <= 8'd0;
            end
        end
    end

    always_comb begin
        next_state = state;
        load_ir    = 1'b0;
        set_fault  = 1'b0;
        if (!run) begin
            next_state = F_ADDR;
        end else begin
            case (state)
                F_ADDR: next_state = F_MEM;
                F_MEM: begin
                    if (MFC) begin
                        next_state = F_RD;
                    end else if (timed_out) begin
                        next_state = HALT;
                        set_fault  = 1'b1;
                    end
                end
                F_RD: next_state = F_IR;
                F_IR: begin
                    next_state = DECODE;
                    load_ir    = 1'b1;
                end
                DECODE: begin
                    case (ir[15:12])
                        4'h1:    next_state = A0;
                        4'h2:    next_state = L_A;
                        4'h3:    next_state = S_A;
                        4'h4:    next_state = MV;
`ifdef CU_IO_INSTR_EN
                        4'h5:    next_state = I_R;
                        4'h6:    next_state = O_W;
`endif
                        4'hF:    next_state = HALT;
                        default: next_state = F_ADDR;
                    endcase
                end
                A0: next_state = A1;
                A1: next_state = AL;
                AL: next_state = AW;
                AW: next_state = F_ADDR;
                L_A: next_state = L_M;
                L_M: begin
                    if (MFC) begin
                        next_state = L_D;
                    end else if (timed_out) begin
                        next_state = HALT;
                        set_fault  = 1'b1;
                    end
                end
                L_D: next_state = L_W;
                L_W: next_state = F_ADDR;
                S_A: next_state = S_D;
                S_D: next_state = S_M;
                S_M: begin
                    if (MFC) begin
                        next_state = F_ADDR;
                    end else if (timed_out) begin
                        next_state = HALT;
                        set_fault  = 1'b1;
                    end
                end
                MV:      next_state = F_ADDR;
                I_R:     next_state = F_ADDR;
                O_W:     next_state = F_ADDR;
                HALT:    next_state = HALT;
                default: next_state = F_ADDR;
            endcase
        end
    end

    // Strobe decode: a function of state and IR only
    always_comb begin
        ALUin0      = 1'b0;
        ALUin1      = 1'b0;
        ALUOutLatch = 1'b0;
        ALUOutEn    = 1'b0;
        opControl   = 3'd0;
        PCOutEn     = 1'b0;
        PCInc       = 1'b0;
        rLatch      = 4'b0000;
        rOut        = 4'b0000;
        memEN       = 1'b0;
        memRW       = 1'b0;
        MARin       = 1'b0;
        MDRwriteEN  = 1'b0;
        MDRreadEN   = 1'b0;
        MDRout      = 1'b0;
        p0Latch     = 1'b0;
        p1Out       = 1'b0;
        halted      = 1'b0;
        if (run) begin
            case (state)
                F_ADDR: begin
                    PCOutEn = 1'b1;
                    MARin   = 1'b1;
                end
                F_MEM: begin
                    memEN = 1'b1;
                    memRW = 1'b1;
                end
                F_RD: MDRreadEN = 1'b1;
                F_IR: begin
                    MDRout = 1'b1;
                    PCInc  = 1'b1;
                end
                A0: begin
                    rOut   = rd_oh;
                    ALUin0 = 1'b1;
                end
                A1: begin
                    rOut   = rs_oh;
                    ALUin1 = 1'b1;
                end
                AL: begin
                    ALUOutLatch = 1'b1;
                    opControl   = ir[7:5];
                end
                AW: begin
                    ALUOutEn = 1'b1;
                    rLatch   = rd_oh;
                end
                L_A: begin
                    rOut  = rs_oh;
                    MARin = 1'b1;
                end
                L_M: begin
                    memEN = 1'b1;
                    memRW = 1'b1;
                end
                L_D: MDRreadEN = 1'b1;
                L_W: begin
                    MDRout = 1'b1;
                    rLatch = rd_oh;
                end
                S_A: begin
                    rOut  = rs_oh;
                    MARin = 1'b1;
                end
                S_D: begin
                    rOut       = rd_oh;
                    MDRwriteEN = 1'b1;
                end
                S_M: memEN = 1'b1;
                MV: begin
                    rOut   = rs_oh;
                    rLatch = rd_oh;
                end
`ifdef CU_IO_INSTR_EN
                I_R: begin
                    p1Out  = 1'b1;
                    rLatch = rd_oh;
                end
                O_W: begin
                    rOut    = rs_oh;
                    p0Latch = 1'b1;
                end
`endif
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit

module tb_control_unit;

    typedef struct packed {
        logic       alu_in0, alu_in1, alu_out_latch, alu_out_en;
        logic [2:0] op_control;
        logic       pc_out_en, pc_inc;
        logic [3:0] r_latch, r_out;
        logic       mem_en, mem_rw, mar_in, mdr_write_en, mdr_read_en, mdr_out;
        logic       p0_latch, p1_out, halted, mem_fault;
    } outs_t;

    typedef struct {
        outs_t       exp;
        logic        mfc;
        logic [15:0] bus;
    } step_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] busIn = 16'h0000;
    logic        MFC = 1'b0;

    wire a_ai0, a_ai1, a_aol, a_aoe, a_pco, a_pci, a_men, a_mrw, a_mar, a_mdw, a_mdr, a_mdo;
    wire a_p0, a_p1, a_hlt, a_flt;
    wire [2:0] a_op;
    wire [3:0] a_rl, a_ro;
    wire b_ai0, b_ai1, b_aol, b_aoe, b_pco, b_pci, b_men, b_mrw, b_mar, b_mdw, b_mdr, b_mdo;
    wire b_p0, b_p1, b_hlt, b_flt;
    wire [2:0] b_op;
    wire [3:0] b_rl, b_ro;

    outs_t oa, ob;
    assign oa = {a_ai0, a_ai1, a_aol, a_aoe, a_op, a_pco, a_pci, a_rl, a_ro,
                 a_men, a_mrw, a_mar, a_mdw, a_mdr, a_mdo, a_p0, a_p1, a_hlt, a_flt};
    assign ob = {b_ai0, b_ai1, b_aol, b_aoe, b_op, b_pco, b_pci, b_rl, b_ro,
                 b_men, b_mrw, b_mar, b_mdw, b_mdr, b_mdo, b_p0, b_p1, b_hlt, b_flt};

    control_unit #(.MFC_TIMEOUT(7)) dut (
        .clk(clk), .rst(rst), .busIn(busIn), .MFC(MFC),
        .ALUin0(a_ai0), .ALUin1(a_ai1), .ALUOutLatch(a_aol), .ALUOutEn(a_aoe),
        .opControl(a_op), .PCOutEn(a_pco), .PCInc(a_pci), .rLatch(a_rl), .rOut(a_ro),
        .memEN(a_men), .memRW(a_mrw), .MARin(a_mar), .MDRwriteEN(a_mdw),
        .MDRreadEN(a_mdr), .MDRout(a_mdo), .p0Latch(a_p0), .p1Out(a_p1),
        .halted(a_hlt), .memFault(a_flt)
    );

    control_unit #(.MFC_TIMEOUT(4)) dut4 (
        .clk(clk), .rst(rst), .busIn(busIn), .MFC(MFC),
        .ALUin0(b_ai0), .ALUin1(b_ai1), .ALUOutLatch(b_aol), .ALUOutEn(b_aoe),
        .opControl(b_op), .PCOutEn(b_pco), .PCInc(b_pci), .rLatch(b_rl), .rOut(b_ro),
        .memEN(b_men), .memRW(b_mrw), .MARin(b_mar), .MDRwriteEN(b_mdw),
        .MDRreadEN(b_mdr), .MDRout(b_mdo), .p0Latch(b_p0), .p1Out(b_p1),
        .halted(b_hlt), .memFault(b_flt)
    );

    always #5 clk = ~clk;

    int      n_assert = 0;
    int      n_fail   = 0;
    int      tmo      = 7;
    bit      use4     = 1'b0;
    step_t   steps[$];
    outs_t   obs[$];

    function automatic logic [3:0] oh(input int n);
        logic [3:0] v;
        v = 4'b0001;
        return v << n;
    endfunction

    task automatic put(input outs_t o, input logic mfc, input logic [15:0] bus);
        step_t s;
        s.exp = o;
        s.mfc = mfc;
        s.bus = bus;
        steps.push_back(s);
    endtask

    task automatic put_r(input outs_t o);
        put(o, 1'($urandom), 16'($urandom));
    endtask

    // d = cycle on which MFC is seen (1 = already high on entry); 0 or beyond
    // the timeout means MFC never arrives in time
    task automatic put_wait(input outs_t o, input int d, output bit fault);
        fault = 1'b0;
        if (d == 0 || d > tmo) begin
            for (int k = 0; k < tmo; k++) put(o, 1'b0, 16'($urandom));
            fault = 1'b1;
        end else begin
            for (int k = 1; k < d; k++) put(o, 1'b0, 16'($urandom));
            put(o, 1'b1, 16'($urandom));
        end
    endtask

    task automatic put_halt(input bit fault, input int n);
        outs_t o;
        o = '0;
        o.halted    = 1'b1;
        o.mem_fault = fault;
        for (int k = 0; k < n; k++) put_r(o);
    endtask

    // Expected cycle-by-cycle behaviour of one fetched instruction
    task automatic add_instr(input logic [15:0] ir, input int df, input int dx, output bit stop);
        outs_t o;
        bit    f;
        int    rd, rs;
        rd   = int'(ir[11:10]);
        rs   = int'(ir[9:8]);
        stop = 1'b0;
        o = '0; o.pc_out_en = 1'b1; o.mar_in = 1'b1; put_r(o);
        o = '0; o.mem_en = 1'b1; o.mem_rw = 1'b1; put_wait(o, df, f);
        if (f) begin put_halt(1'b1, 3); stop = 1'b1; return; end
        o = '0; o.mdr_read_en = 1'b1; put_r(o);
        o = '0; o.mdr_out = 1'b1; o.pc_inc = 1'b1; put(o, 1'($urandom), ir);
        o = '0; put_r(o);
        case (ir[15:12])
            4'h1: begin
                o = '0; o.r_out = oh(rd); o.alu_in0 = 1'b1; put_r(o);
                o = '0; o.r_out = oh(rs); o.alu_in1 = 1'b1; put_r(o);
                o = '0; o.alu_out_latch = 1'b1; o.op_control = ir[7:5]; put_r(o);
                o = '0; o.alu_out_en = 1'b1; o.r_latch = oh(rd); put_r(o);
            end
            4'h2: begin
                o = '0; o.r_out = oh(rs); o.mar_in = 1'b1; put_r(o);
                o = '0; o.mem_en = 1'b1; o.mem_rw = 1'b1; put_wait(o, dx, f);
                if (f) begin put_halt(1'b1, 3); stop = 1'b1; return; end
                o = '0; o.mdr_read_en = 1'b1; put_r(o);
                o = '0; o.mdr_out = 1'b1; o.r_latch = oh(rd); put_r(o);
            end
            4'h3: begin
                o = '0; o.r_out = oh(rs); o.mar_in = 1'b1; put_r(o);
                o = '0; o.r_out = oh(rd); o.mdr_write_en = 1'b1; put_r(o);
                o = '0; o.mem_en = 1'b1; put_wait(o, dx, f);
                if (f) begin put_halt(1'b1, 3); stop = 1'b1; return; end
            end
            4'h4: begin
                o = '0; o.r_out = oh(rs); o.r_latch = oh(rd); put_r(o);
            end
`ifdef CU_IO_INSTR_EN
            4'h5: begin
                o = '0; o.p1_out = 1'b1; o.r_latch = oh(rd); put_r(o);
            end
            4'h6: begin
                o = '0; o.r_out = oh(rs); o.p0_latch = 1'b1; put_r(o);
            end
`endif
            4'hF: begin
                put_halt(1'b0, 4);
                stop = 1'b1;
            end
            default: ;
        endcase
    endtask

    // Drives the step table and records the observed outputs; starts and ends
    // 1 time unit after a rising edge
    task automatic exec(input int n);
        obs.delete();
        for (int i = 0; i < steps.size(); i++) begin
            if (n >= 0 && i >= n) break;
            MFC   = steps[i].mfc;
            busIn = steps[i].bus;
            @(negedge clk);
            obs.push_back(use4 ? ob : oa);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        steps.delete();
    endtask

    task automatic test_reset();
        bit stop;
        #12;
        n_assert++;
        if (oa !== '0 || ob !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h / %h required 0", oa, ob);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_assert++;
        if (oa !== '0) begin
            n_fail++;
            $display("FAIL reset_release_partial: got %h required 0", oa);
        end
        @(posedge clk);
        #1;
        steps.delete();
        add_instr(16'h0000, 1, 1, stop);
        add_instr(16'h0000, 1, 1, stop);
        exec(-1);
        foreach (obs[i]) begin
            n_assert++;
            if (obs[i] !== steps[i].exp) begin
                n_fail++;
                $display("FAIL fetch step %0d: got %h required %h", i, obs[i], steps[i].exp);
            end
        end
    endtask

    task automatic test_alu();
        bit stop;
        do_reset();
        add_instr(16'h1640, 1, 1, stop);
        add_instr(16'h15E0, 3, 1, stop);
        add_instr(16'h1C1F, 1, 1, stop);
        exec(-1);
        foreach (obs[i]) begin
            n_assert++;
            if (obs[i] !== steps[i].exp) begin
                n_fail++;
                $display("FAIL alu step %0d: got %h required %h", i, obs[i], steps[i].exp);
            end
        end
    endtask

    task automatic test_load_store();
        bit stop;
        do_reset();
        add_instr(16'h2300, 2, 5, stop);
        add_instr(16'h2E00, 1, 1, stop);
        add_instr(16'h3900, 1, 3, stop);
        add_instr(16'h3600, 7, 7, stop);
        exec(-1);
        foreach (obs[i]) begin
            n_assert++;
            if (obs[i] !== steps[i].exp) begin
                n_fail++;
                $display("FAIL load_store step %0d: got %h required %h", i, obs[i], steps[i].exp);
            end
        end
    endtask

    task automatic test_mov_nop_io();
        bit stop;
        do_reset();
        add_instr(16'h4500, 1, 1, stop);
        add_instr(16'h4B00, 1, 1, stop);
        add_instr(16'h7ABC, 1, 1, stop);
        add_instr(16'hE123, 2, 1, stop);
        add_instr(16'h6100, 1, 1, stop);
        add_instr(16'h5C00, 1, 1, stop);
        add_instr(16'h0000, 1, 1, stop);
        exec(-1);
        foreach (obs[i]) begin
            n_assert++;
            if (obs[i] !== steps[i].exp) begin
                n_fail++;
                $display("FAIL mov_nop_io step %0d: got %h required %h", i, obs[i], steps[i].exp);
            end
        end
    endtask

    task automatic test_halt();
        bit stop;
        do_reset();
        add_instr(16'h4100, 1, 1, stop);
        add_instr(16'hF000, 1, 1, stop);
        exec(-1);
        foreach (obs[i]) begin
            n_assert++;
            if (obs[i] !== steps[i].exp) begin
                n_fail++;
                $display("FAIL halt step %0d: got %h required %h", i, obs[i], steps[i].exp);
            end
        end
    endtask

    task automatic test_timeout();
        bit stop;
        use4 = 1'b1;
        tmo  = 4;
        do_reset();
        add_instr(16'h3200, 1, 0, stop);
        exec(-1);
        foreach (obs[i]) begin
            n_assert++;
            if (obs[i] !== steps[i].exp) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %h required %h", i, obs[i], steps[i].exp);
            end
        end
        use4 = 1'b0;
        tmo  = 7;
    endtask

    task automatic test_reset_mid();
        bit stop;
        do_reset();
        add_instr(16'h3600, 1, 0, stop);
        exec(9);
        foreach (obs[i]) begin
            n_assert++;
            if (obs[i] !== steps[i].exp) begin
                n_fail++;
                $display("FAIL pre_reset step %0d: got %h required %h", i, obs[i], steps[i].exp);
            end
        end
        #2 rst = 1'b1;
        MFC = 1'b1;
        #1;
        n_assert++;
        if (oa !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h required 0", oa);
        end
        @(posedge clk);
        #1;
        n_assert++;
        if (oa !== '0) begin
            n_fail++;
            $display("FAIL reset_edge: got %h required 0", oa);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_assert++;
        if (oa !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_release: got %h required 0", oa);
        end
        @(posedge clk);
        #1;
        steps.delete();
        add_instr(16'h0000, 2, 1, stop);
        add_instr(16'h1640, 1, 1, stop);
        exec(-1);
        foreach (obs[i]) begin
            n_assert++;
            if (obs[i] !== steps[i].exp) begin
                n_fail++;
                $display("FAIL post_reset step %0d: got %h required %h", i, obs[i], steps[i].exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit          stop;
        logic [3:0]  op;
        logic [15:0] ir;
        int          df, dx;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            stop = 1'b0;
            for (int k = 0; k < 30 && !stop; k++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h1;
                ir = {op, 12'($urandom)};
                df = ($urandom_range(0, 30) == 0) ? 0 : $urandom_range(1, tmo);
                dx = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, tmo);
                add_instr(ir, df, dx, stop);
            end
            exec(-1);
            foreach (obs[i]) begin
                n_assert++;
                if (obs[i] !== steps[i].exp) begin
                    n_fail++;
                    $display("FAIL random run %0d step %0d: got %h required %h", r, i, obs[i], steps[i].exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_mov_nop_io();
        test_halt();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
